// File: rtl/pcie_ptile_tx_fc_gate_if.sv
// Request/grant and credit-status bundle between the TX scheduler (master)
// and the flow-control credit gate (slave).
interface pcie_ptile_tx_fc_gate_if #(
  parameter int REQ_COUNT      = 2,
  parameter int HDR_CNT_WIDTH  = 12,
  parameter int DATA_CNT_WIDTH = 16
);
  logic [15:0]                 tx_cdts_limit;
  logic [2:0]                  tx_cdts_limit_tdm_idx;
  logic [REQ_COUNT-1:0]        req_valid;
  logic [REQ_COUNT*2-1:0]      req_type;
  logic [REQ_COUNT*11-1:0]     req_len_dw;
  logic [REQ_COUNT-1:0]        req_ready;
  logic [3*HDR_CNT_WIDTH-1:0]  hdr_avail;
  logic [3*DATA_CNT_WIDTH-1:0] data_avail;
  logic                        type_err;

  modport master (
    output tx_cdts_limit, tx_cdts_limit_tdm_idx, req_valid, req_type, req_len_dw,
    input  req_ready, hdr_avail, data_avail, type_err
  );

  modport slave (
    input  tx_cdts_limit, tx_cdts_limit_tdm_idx, req_valid, req_type, req_len_dw,
    output req_ready, hdr_avail, data_avail, type_err
  );
endinterface

// File: rtl/pcie_ptile_tx_fc_gate.sv
// P-tile TX credit gate: captures TDM credit limits, tracks consumed credits
// and grants up to REQ_COUNT in-order TLP segments per cycle.
module pcie_ptile_tx_fc_gate #(
  parameter int REQ_COUNT      = 2,
  parameter int HDR_CNT_WIDTH  = 12,
  parameter int DATA_CNT_WIDTH = 16,
  parameter bit CPL_INFINITE   = 1'b0
) (
  input  logic                     coreclkout_hip,
  input  logic                     reset_status_n,
  pcie_ptile_tx_fc_gate_if.slave   bus
);

  localparam int HW  = HDR_CNT_WIDTH;
  localparam int DW  = DATA_CNT_WIDTH;
  // Cumulative costs get headroom so a multi-segment sum never wraps before the compare.
  localparam int HCW = ((HW > 3) ? HW : 3) + 1;
  localparam int DCW = ((DW > 12) ? DW : 12) + 1;

  typedef enum logic [1:0] {
    T_P   = 2'd0,
    T_NP  = 2'd1,
    T_CPL = 2'd2,
    T_ILL = 2'd3
  } tlp_type_e;

  logic [HW-1:0]  r_hdr_lim   [3];
  logic [HW-1:0]  r_hdr_cons  [3];
  logic [DW-1:0]  r_data_lim  [3];
  logic [DW-1:0]  r_data_cons [3];
  logic [2:0]     r_hdr_seen;
  logic [2:0]     r_data_seen;
  logic           r_type_err;

  logic [HW-1:0]  w_hdr_diff   [3];
  logic [HW-1:0]  w_hdr_avail  [3];
  logic [DW-1:0]  w_data_diff  [3];
  logic [DW-1:0]  w_data_avail [3];

  logic [HCW-1:0] w_hdr_cum  [3];
  logic [DCW-1:0] w_data_cum [3];
  logic [DCW-1:0] w_data_cost;
  logic [1:0]     w_tidx;
  tlp_type_e      w_type;
  logic           w_blocked;
  logic           w_fits;
  logic           w_ill_req;
  logic [REQ_COUNT-1:0] w_ready;

  // A negative difference means the limit is behind consumption: report zero.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      w_hdr_diff[t]   = r_hdr_lim[t] - r_hdr_cons[t];
      w_data_diff[t]  = r_data_lim[t] - r_data_cons[t];
      w_hdr_avail[t]  = w_hdr_diff[t][HW-1]  ? '0 : w_hdr_diff[t];
      w_data_avail[t] = w_data_diff[t][DW-1] ? '0 : w_data_diff[t];
      if (CPL_INFINITE && (t == 2)) begin
        w_hdr_avail[t]  = '1;
        w_data_avail[t] = '1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_avail
    assign bus.hdr_avail[g*HW +: HW]  = w_hdr_avail[g];
    assign bus.data_avail[g*DW +: DW] = w_data_avail[g];
  end

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  // NOTE: blocking assignments here are deliberate; each segment must see the
  // running totals and blocked flag left by the segments below it.
  always_comb begin
    w_ready     = '0;
    w_blocked   = 1'b0;
    w_fits      = 1'b0;
    w_ill_req   = 1'b0;
    w_tidx      = 2'd0;
    w_type      = T_P;
    w_data_cost = '0;
    for (int t = 0; t < 3; t++) begin
      w_hdr_cum[t]  = '0;
      w_data_cum[t] = '0;
    end
    for (int i = 0; i < REQ_COUNT; i++) begin
      w_tidx      = bus.req_type[2*i +: 2];
      w_type      = tlp_type_e'(w_tidx);
      w_data_cost = DCW'((12'(bus.req_len_dw[11*i +: 11]) + 12'd3) >> 2);
      if (bus.req_valid[i] && (w_type == T_ILL)) w_ill_req = 1'b1;
      // An invalid or illegal segment stops the in-order walk for all higher segments.
      if (!bus.req_valid[i] || (w_type == T_ILL)) w_blocked = 1'b1;
      if (!w_blocked) begin
        w_fits = (CPL_INFINITE && (w_type == T_CPL)) ||
                 (r_hdr_seen[w_tidx] && r_data_seen[w_tidx] &&
                  ((w_hdr_cum[w_tidx] + HCW'(1)) <= HCW'(w_hdr_avail[w_tidx])) &&
                  ((w_data_cum[w_tidx] + w_data_cost) <= DCW'(w_data_avail[w_tidx])));
        if (w_fits) begin
          w_ready[i]         = 1'b1;
          w_hdr_cum[w_tidx]  = w_hdr_cum[w_tidx] + HCW'(1);
          w_data_cum[w_tidx] = w_data_cum[w_tidx] + w_data_cost;
        end else begin
          w_blocked = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.type_err  = r_type_err;

  // NOTE: the limit/consumed arrays are small register files that must clear
  // on reset, so each entry is reset explicitly rather than left as memory.
  always_ff @(posedge coreclkout_hip) begin
    if (!reset_status_n) begin
      for (int t = 0; t < 3; t++) begin
        r_hdr_lim[t]   <= '0;
        r_hdr_cons[t]  <= '0;
        r_data_lim[t]  <= '0;
        r_data_cons[t] <= '0;
      end
      r_hdr_seen  <= '0;
      r_data_seen <= '0;
      r_type_err  <= 1'b0;
    end else begin
      for (int t = 0; t < 3; t++) begin
        r_hdr_cons[t]  <= r_hdr_cons[t] + HW'(w_hdr_cum[t]);
        r_data_cons[t] <= r_data_cons[t] + DW'(w_data_cum[t]);
      end
      case (bus.tx_cdts_limit_tdm_idx)
        3'd0, 3'd1, 3'd2: begin
          r_hdr_lim[bus.tx_cdts_limit_tdm_idx[1:0]]  <= HW'(bus.tx_cdts_limit);
          r_hdr_seen[bus.tx_cdts_limit_tdm_idx[1:0]] <= 1'b1;
        end
        3'd4, 3'd5, 3'd6: begin
          r_data_lim[bus.tx_cdts_limit_tdm_idx[1:0]]  <= DW'(bus.tx_cdts_limit);
          r_data_seen[bus.tx_cdts_limit_tdm_idx[1:0]] <= 1'b1;
        end
        default: ;
      endcase
      if (w_ill_req) r_type_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_ptile_tx_fc_gate.sv
// Bench for the TX credit gate: directed scenarios plus randomized traffic
// checked against a credit-ledger model, on CPL_INFINITE=0 and =1 instances.
module tb_pcie_ptile_tx_fc_gate;

  localparam int RC = 2;
  localparam int H  = 12;
  localparam int D  = 16;
  localparam int HM = (1 << H) - 1;
  localparam int DM = (1 << D) - 1;
  localparam logic [1:0] TP = 2'd0, TNP = 2'd1, TCPL = 2'd2, TILL = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            tb_rst_n = 1'b0;
  logic [15:0]     tb_limit = '0;
  logic [2:0]      tb_idx   = 3'd3;
  logic [RC-1:0]   tb_valid = '0;
  logic [RC*2-1:0] tb_type  = '0;
  logic [RC*11-1:0] tb_len  = '0;

  int checks = 0;
  int errors = 0;

  pcie_ptile_tx_fc_gate_if #(.REQ_COUNT(RC), .HDR_CNT_WIDTH(H), .DATA_CNT_WIDTH(D)) bus0 ();
  pcie_ptile_tx_fc_gate_if #(.REQ_COUNT(RC), .HDR_CNT_WIDTH(H), .DATA_CNT_WIDTH(D)) bus1 ();

  assign bus0.tx_cdts_limit = tb_limit;  assign bus1.tx_cdts_limit = tb_limit;
  assign bus0.tx_cdts_limit_tdm_idx = tb_idx;  assign bus1.tx_cdts_limit_tdm_idx = tb_idx;
  assign bus0.req_valid = tb_valid;  assign bus1.req_valid = tb_valid;
  assign bus0.req_type = tb_type;    assign bus1.req_type = tb_type;
  assign bus0.req_len_dw = tb_len;   assign bus1.req_len_dw = tb_len;

  pcie_ptile_tx_fc_gate #(.REQ_COUNT(RC), .HDR_CNT_WIDTH(H), .DATA_CNT_WIDTH(D),
                          .CPL_INFINITE(1'b0)) u_dut0 (
    .coreclkout_hip(clk), .reset_status_n(tb_rst_n), .bus(bus0));
  pcie_ptile_tx_fc_gate #(.REQ_COUNT(RC), .HDR_CNT_WIDTH(H), .DATA_CNT_WIDTH(D),
                          .CPL_INFINITE(1'b1)) u_dut1 (
    .coreclkout_hip(clk), .reset_status_n(tb_rst_n), .bus(bus1));

  // Credit ledger per instance k (0: finite CPL, 1: infinite CPL), per type t.
  int m_hl [2][3];
  int m_dl [2][3];
  int m_hc [2][3];
  int m_dc [2][3];
  bit m_hs [2][3];
  bit m_ds [2][3];
  bit m_err[2];

  function automatic int cost_of(input int len);
    return (len + 3) / 4;
  endfunction

  function automatic int m_avail_h(input int k, input int t);
    int d;
    if (k == 1 && t == 2) return HM;
    d = (m_hl[k][t] - m_hc[k][t]) & HM;
    return (d >= (1 << (H - 1))) ? 0 : d;
  endfunction

  function automatic int m_avail_d(input int k, input int t);
    int d;
    if (k == 1 && t == 2) return DM;
    d = (m_dl[k][t] - m_dc[k][t]) & DM;
    return (d >= (1 << (D - 1))) ? 0 : d;
  endfunction

  function automatic logic [RC-1:0] m_ready(input int k);
    int hn[3];
    int dn[3];
    bit stop;
    logic [RC-1:0] r;
    hn = '{0, 0, 0};
    dn = '{0, 0, 0};
    stop = 1'b0;
    r = '0;
    for (int i = 0; i < RC; i++) begin
      int t;
      t = int'(tb_type[2*i +: 2]);
      if (stop || !tb_valid[i] || t == 3) begin
        stop = 1'b1;
      end else begin
        hn[t] += 1;
        dn[t] += cost_of(int'(tb_len[11*i +: 11]));
        if ((k == 1 && t == 2) ||
            (m_hs[k][t] && m_ds[k][t] && hn[t] <= m_avail_h(k, t) && dn[t] <= m_avail_d(k, t)))
          r[i] = 1'b1;
        else
          stop = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [RC-1:0] dut_ready(input int k);
    return (k == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic int dut_h(input int k, input int t);
    return int'((k == 0) ? bus0.hdr_avail[t*H +: H] : bus1.hdr_avail[t*H +: H]);
  endfunction
  function automatic int dut_d(input int k, input int t);
    return int'((k == 0) ? bus0.data_avail[t*D +: D] : bus1.data_avail[t*D +: D]);
  endfunction
  function automatic logic dut_err(input int k);
    return (k == 0) ? bus0.type_err : bus1.type_err;
  endfunction

  // Advance one clock and apply the same edge to the ledger.
  task automatic tick();
    logic [RC-1:0] e[2];
    e[0] = m_ready(0);
    e[1] = m_ready(1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!tb_rst_n) begin
        for (int t = 0; t < 3; t++) begin
          m_hl[k][t] = 0; m_dl[k][t] = 0; m_hc[k][t] = 0; m_dc[k][t] = 0;
          m_hs[k][t] = 0; m_ds[k][t] = 0;
        end
        m_err[k] = 0;
      end else begin
        for (int i = 0; i < RC; i++) begin
          int t;
          t = int'(tb_type[2*i +: 2]);
          if (e[k][i]) begin
            m_hc[k][t] = (m_hc[k][t] + 1) & HM;
            m_dc[k][t] = (m_dc[k][t] + cost_of(int'(tb_len[11*i +: 11]))) & DM;
          end
          if (tb_valid[i] && t == 3) m_err[k] = 1'b1;
        end
        if (tb_idx <= 3'd2) begin
          m_hl[k][tb_idx] = int'(tb_limit) & HM;
          m_hs[k][tb_idx] = 1'b1;
        end else if (tb_idx >= 3'd4 && tb_idx <= 3'd6) begin
          m_dl[k][tb_idx - 4] = int'(tb_limit) & DM;
          m_ds[k][tb_idx - 4] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] t0, input int l0,
                         input logic [1:0] t1, input int l1);
    tb_valid = v;
    tb_type  = {t1, t0};
    tb_len   = {11'(l1), 11'(l0)};
  endtask

  task automatic do_reset();
    tb_rst_n = 1'b0;
    tb_idx   = 3'd3;
    tb_limit = '0;
    set_req(2'b00, TP, 0, TP, 0);
    tick();
    tb_rst_n = 1'b1;
  endtask

  task automatic load(input logic [2:0] idx, input int value);
    tb_idx   = idx;
    tb_limit = 16'(value);
    tick();
    tb_idx   = 3'd3;
  endtask

  task automatic test_reset();
    tb_rst_n = 1'b0;
    tick();
    tick();
    set_req(2'b01, TP, 4, TP, 0);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", dut_ready(0)); end
    checks++; if (bus0.hdr_avail !== '0) begin errors++; $display("FAIL reset_hdr got %h want 0", bus0.hdr_avail); end
    checks++; if (bus0.data_avail !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus0.data_avail); end
    checks++; if (bus0.type_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus0.type_err); end
    checks++; if (bus1.hdr_avail !== {12'hFFF, 24'h0}) begin errors++; $display("FAIL reset_hdr_inf got %h want fff000000", bus1.hdr_avail); end
    tb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_limit_capture();
    do_reset();
    set_req(2'b01, TP, 4, TP, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL nolimit_ready cyc %0d got %b want 00", c, dut_ready(0)); end
      tick();
    end
    tb_idx = 3'd0; tb_limit = 16'd2;
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL ph_cap_ready got %b want 00", dut_ready(0)); end
    tick();
    tb_idx = 3'd4; tb_limit = 16'd4;
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL pd_cap_ready got %b want 00", dut_ready(0)); end
    tick();
    tb_idx = 3'd3;
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b01) begin errors++; $display("FAIL cap_grant got %b want 01", dut_ready(0)); end
    checks++; if (dut_h(0, 0) !== 2) begin errors++; $display("FAIL cap_hdr_p got %0d want 2", dut_h(0, 0)); end
    checks++; if (dut_d(0, 0) !== 4) begin errors++; $display("FAIL cap_data_p got %0d want 4", dut_d(0, 0)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
    @(negedge clk);
    checks++; if (dut_h(0, 0) !== 1) begin errors++; $display("FAIL used_hdr_p got %0d want 1", dut_h(0, 0)); end
    checks++; if (dut_d(0, 0) !== 3) begin errors++; $display("FAIL used_data_p got %0d want 3", dut_d(0, 0)); end
    tick();
  endtask

  task automatic test_partial_grant();
    do_reset();
    load(3'd0, 1);
    load(3'd4, 8);
    set_req(2'b11, TP, 16, TP, 16);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b01) begin errors++; $display("FAIL partial_ready got %b want 01", dut_ready(0)); end
    tick();
    set_req(2'b01, TP, 16, TP, 0);
    tb_idx = 3'd0; tb_limit = 16'd2;
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL nohdr_ready got %b want 00", dut_ready(0)); end
    tick();
    tb_idx = 3'd3;
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b01) begin errors++; $display("FAIL regrant_ready got %b want 01", dut_ready(0)); end
    checks++; if (dut_d(0, 0) !== 4) begin errors++; $display("FAIL regrant_data got %0d want 4", dut_d(0, 0)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
  endtask

  task automatic test_order_gap();
    do_reset();
    load(3'd0, 100);
    load(3'd4, 1000);
    load(3'd5, 1000);
    set_req(2'b10, TP, 4, TP, 4);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL gap_ready got %b want 00", dut_ready(0)); end
    tick();
    set_req(2'b11, TNP, 0, TP, 4);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL np_block_ready got %b want 00", dut_ready(0)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
    load(3'd1, 0);
    set_req(2'b11, TNP, 0, TP, 4);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL np_zero_ready got %b want 00", dut_ready(0)); end
    tick();
    set_req(2'b11, TP, 4, TP, 8);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b11) begin errors++; $display("FAIL pp_ready got %b want 11", dut_ready(0)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
  endtask

  task automatic test_wrap();
    int rem;
    int chunk;
    do_reset();
    load(3'd0, 2000);
    for (int c = 0; c < 400 && m_dc[0][0] != 'hFFFE; c++) begin
      rem   = 'hFFFE - m_dc[0][0];
      chunk = (rem > 256) ? 256 : rem;
      set_req(2'b01, TP, chunk * 4, TP, 0);
      tb_idx   = 3'd4;
      tb_limit = 16'((m_dc[0][0] + 'h4000) & DM);
      @(negedge clk);
      checks++; if (dut_ready(0) !== m_ready(0)) begin errors++; $display("FAIL ramp_ready cyc %0d got %b want %b", c, dut_ready(0), m_ready(0)); end
      tick();
    end
    set_req(2'b00, TP, 0, TP, 0);
    load(3'd4, 'h0002);
    set_req(2'b01, TP, 8, TP, 0);
    @(negedge clk);
    checks++; if (dut_d(0, 0) !== 4) begin errors++; $display("FAIL wrap_avail_pre got %0d want 4", dut_d(0, 0)); end
    checks++; if (dut_ready(0) !== 2'b01) begin errors++; $display("FAIL wrap_ready got %b want 01", dut_ready(0)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
    @(negedge clk);
    checks++; if (dut_d(0, 0) !== 2) begin errors++; $display("FAIL wrap_avail_post got %0d want 2", dut_d(0, 0)); end
    checks++; if (dut_h(0, 0) !== 1743) begin errors++; $display("FAIL wrap_hdr got %0d want 1743", dut_h(0, 0)); end
    tick();
  endtask

  task automatic test_cpl_infinite_and_err();
    do_reset();
    set_req(2'b01, TCPL, 1024, TP, 0);
    @(negedge clk);
    checks++; if (dut_ready(1) !== 2'b01) begin errors++; $display("FAIL cplinf_ready got %b want 01", dut_ready(1)); end
    checks++; if (dut_ready(0) !== 2'b00) begin errors++; $display("FAIL cplfin_ready got %b want 00", dut_ready(0)); end
    checks++; if (dut_d(1, 2) !== DM) begin errors++; $display("FAIL cplinf_data got %0d want %0d", dut_d(1, 2), DM); end
    tick();
    set_req(2'b11, TILL, 0, TCPL, 4);
    @(negedge clk);
    checks++; if (dut_ready(1) !== 2'b00) begin errors++; $display("FAIL illegal_ready got %b want 00", dut_ready(1)); end
    checks++; if (dut_err(1) !== 1'b0) begin errors++; $display("FAIL err_early got %b want 0", dut_err(1)); end
    tick();
    set_req(2'b00, TP, 0, TP, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (dut_err(0) !== 1'b1 || dut_err(1) !== 1'b1) begin errors++; $display("FAIL err_sticky cyc %0d got %b%b want 11", c, dut_err(0), dut_err(1)); end
      tick();
    end
    do_reset();
    @(negedge clk);
    checks++; if (dut_err(1) !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", dut_err(1)); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    load(3'd0, 5);
    load(3'd4, 100);
    set_req(2'b01, TP, 0, TP, 0);
    @(negedge clk);
    checks++; if (dut_ready(0) !== 2'b01) begin errors++; $display("FAIL same_first got %b want 01", dut_ready(0)); end
    tick();
    tb_idx = 3'd0; tb_limit = 16'd6;
    @(negedge clk);
    checks++; if (dut_h(0, 0) !== 4) begin errors++; $display("FAIL same_before got %0d want 4", dut_h(0, 0)); end
    tick();
    tb_idx = 3'd3;
    set_req(2'b00, TP, 0, TP, 0);
    @(negedge clk);
    checks++; if (dut_h(0, 0) !== 4) begin errors++; $display("FAIL same_after got %0d want 4", dut_h(0, 0)); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int t;
      tb_rst_n = ($urandom_range(0, 199) != 0);
      tb_idx   = 3'($urandom_range(0, 7));
      t        = int'(tb_idx) % 4;
      if ($urandom_range(0, 7) == 0)       tb_limit = 16'($urandom);
      else if (tb_idx <= 3'd2)             tb_limit = 16'(m_hc[0][t] + $urandom_range(0, 6));
      else if (tb_idx != 3'd3 && tb_idx != 3'd7) tb_limit = 16'(m_dc[0][t] + $urandom_range(0, 600));
      tb_valid = RC'($urandom);
      for (int i = 0; i < RC; i++) begin
        int r;
        tb_type[2*i +: 2] = ($urandom_range(0, 15) == 0) ? TILL : 2'($urandom_range(0, 2));
        r = $urandom_range(0, 7);
        tb_len[11*i +: 11] = (r == 0) ? 11'd0 : (r == 1) ? 11'd1024 : 11'($urandom_range(1, 64));
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++; if (dut_ready(k) !== m_ready(k)) begin errors++; $display("FAIL rnd_ready k%0d cyc %0d got %b want %b", k, c, dut_ready(k), m_ready(k)); end
        checks++; if (dut_err(k) !== m_err[k]) begin errors++; $display("FAIL rnd_err k%0d cyc %0d got %b want %b", k, c, dut_err(k), m_err[k]); end
        for (int ty = 0; ty < 3; ty++) begin
          checks++; if (dut_h(k, ty) !== m_avail_h(k, ty)) begin errors++; $display("FAIL rnd_hdr k%0d t%0d cyc %0d got %0d want %0d", k, ty, c, dut_h(k, ty), m_avail_h(k, ty)); end
          checks++; if (dut_d(k, ty) !== m_avail_d(k, ty)) begin errors++; $display("FAIL rnd_data k%0d t%0d cyc %0d got %0d want %0d", k, ty, c, dut_d(k, ty), m_avail_d(k, ty)); end
        end
      end
      tick();
    end
    tb_rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_limit_capture();
    test_partial_grant();
    test_order_gap();
    test_wrap();
    test_cpl_infinite_and_err();
    test_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
